spi_peripheral: RTL and testbench

SPI-mode-0 write-only configuration slave that programs the PWM configuration registers of the onboarding design. It samples the off-chip SCLK/COPI/nCS pins, which arrive on `ui_in`, in the `clk` domain and decodes fixed 16-bit frames. It commits each valid write into one of five 8-bit registers: output enables, PWM enables and duty cycle. The PWM generator consumes these registers directly.

---
 rtl/spi_regmap_pkg.sv | 25 ++
 rtl/sync_ff.sv | 25 ++
 rtl/spi_peripheral.sv | 128 ++++++++++++
 tb/tb_spi_peripheral.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_regmap_pkg.sv
// rtl/spi_regmap_pkg.sv - register map, frame geometry and FSM states for the SPI config slave
package spi_regmap_pkg;

    localparam int FRAME_BITS = 16;
    localparam int ADDR_W     = 7;
    localparam int DATA_W     = 8;
    localparam int CNT_W      = 5;

    // Bit counter values: exactly one frame, and the saturated overflow marker.
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0] CNT_OVF  = CNT_W'(FRAME_BITS + 1);

    localparam logic [ADDR_W-1:0] ADDR_EN_OUT_LO = 7'h00;
    localparam logic [ADDR_W-1:0] ADDR_EN_OUT_HI = 7'h01;
    localparam logic [ADDR_W-1:0] ADDR_EN_PWM_LO = 7'h02;
    localparam logic [ADDR_W-1:0] ADDR_EN_PWM_HI = 7'h03;
    localparam logic [ADDR_W-1:0] ADDR_DUTY      = 7'h04;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } spi_state_t;

endpackage

// File: rtl/sync_ff.sv
// rtl/sync_ff.sv - N-stage single-bit synchronizer with selectable reset value
module sync_ff #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    // Shift the asynchronous pin through the flop chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= {STAGES{RST_VAL}};
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/spi_peripheral.sv
// rtl/spi_peripheral.sv - SPI mode-0 write-only slave programming the PWM config registers
module spi_peripheral
    import spi_regmap_pkg::*;
#(
    parameter int                SYNC_STAGES = 2,
    parameter logic [ADDR_W-1:0] MAX_ADDR    = 7'h04
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sclk,
    input  logic              copi,
    input  logic              ncs,
    output logic [DATA_W-1:0] en_reg_out_7_0,
    output logic [DATA_W-1:0] en_reg_out_15_8,
    output logic [DATA_W-1:0] en_reg_pwm_7_0,
    output logic [DATA_W-1:0] en_reg_pwm_15_8,
    output logic [DATA_W-1:0] pwm_duty_cycle
);

    logic sclk_s;
    logic copi_s;
    logic ncs_s;

    // ncs resets high so leaving reset never looks like a chip-select fall.
    sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .d(sclk), .q(sclk_s)
    );
    sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_copi (
        .clk(clk), .rst_n(rst_n), .d(copi), .q(copi_s)
    );
    sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ncs (
        .clk(clk), .rst_n(rst_n), .d(ncs), .q(ncs_s)
    );

    logic sclk_d;
    logic ncs_d;
    logic sclk_rise_p;
    logic ncs_rise_p;

    // Edge detection: previous-level flops plus registered rise pulses. The
    // pulses keep sclk/ncs coincidence intact so the ncs-wins rule is exact.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_d      <= 1'b0;
            ncs_d       <= 1'b1;
            sclk_rise_p <= 1'b0;
            ncs_rise_p  <= 1'b0;
        end else begin
            sclk_d      <= sclk_s;
            ncs_d       <= ncs_s;
            sclk_rise_p <= sclk_s & ~sclk_d;
            ncs_rise_p  <= ncs_s & ~ncs_d;
        end
    end

    spi_state_t            state;
    logic [FRAME_BITS-1:0] shreg;
    logic [CNT_W-1:0]      bit_cnt;

    // Frame FSM. IDLE enters SHIFT on the low ncs level, which also catches a
    // fall that happened during the single COMMIT cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!ncs_d) begin
                        state   <= SHIFT;
                        shreg   <= '0;
                        bit_cnt <= '0;
                    end
                end
                SHIFT: begin
                    if (ncs_rise_p) begin
                        state <= COMMIT;
                    end else if (sclk_rise_p) begin
                        if (bit_cnt < CNT_FULL) begin
                            shreg   <= {shreg[FRAME_BITS-2:0], copi_s};
                            bit_cnt <= bit_cnt + 1'b1;
                        end else begin
                            bit_cnt <= CNT_OVF;
                        end
                    end
                end
                COMMIT: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    logic              wr_bit;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              frame_ok;

    assign wr_bit   = shreg[FRAME_BITS-1];
    assign wr_addr  = shreg[FRAME_BITS-2 -: ADDR_W];
    assign wr_data  = shreg[DATA_W-1:0];
    assign frame_ok = (bit_cnt == CNT_FULL) && wr_bit && (wr_addr <= MAX_ADDR);

    // Register file: a frame is applied only in COMMIT and only if well formed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_reg_out_7_0  <= '0;
            en_reg_out_15_8 <= '0;
            en_reg_pwm_7_0  <= '0;
            en_reg_pwm_15_8 <= '0;
            pwm_duty_cycle  <= '0;
        end else if (state == COMMIT && frame_ok) begin
            case (wr_addr)
                ADDR_EN_OUT_LO: en_reg_out_7_0  <= wr_data;
                ADDR_EN_OUT_HI: en_reg_out_15_8 <= wr_data;
                ADDR_EN_PWM_LO: en_reg_pwm_7_0  <= wr_data;
                ADDR_EN_PWM_HI: en_reg_pwm_15_8 <= wr_data;
                ADDR_DUTY:      pwm_duty_cycle  <= wr_data;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_peripheral.sv
// tb/tb_spi_peripheral.sv - scoreboard bench for spi_peripheral with a frame-level reference model
module tb_spi_peripheral;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       sclk  = 1'b0;
    logic       copi  = 1'b0;
    logic       ncs   = 1'b1;
    logic [7:0] r0, r1, r2, r3, r4;

    spi_peripheral dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .sclk           (sclk),
        .copi           (copi),
        .ncs            (ncs),
        .en_reg_out_7_0 (r0),
        .en_reg_out_15_8(r1),
        .en_reg_pwm_7_0 (r2),
        .en_reg_pwm_15_8(r3),
        .pwm_duty_cycle (r4)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [39:0] regs;
        int          due;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] model[5];
    int         n_cmp  = 0;
    int         n_fail = 0;

    function automatic logic [39:0] model_vec();
        return {model[4], model[3], model[2], model[1], model[0]};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string name);
        check({name, "_r0"}, r0, model[0]);
        check({name, "_r1"}, r1, model[1]);
        check({name, "_r2"}, r2, model[2]);
        check({name, "_r3"}, r3, model[3]);
        check({name, "_r4"}, r4, model[4]);
    endtask

    // Reference: a frame is a write only when it is exactly 16 bits, R/W set,
    // and the address falls in the five-register map. The register changes
    // SYNC_STAGES+2 = 4 edges after the first edge that samples nCS high.
    task automatic model_frame(input logic [31:0] frame, input int nbits, input int due);
        int         addr;
        logic [7:0] data;
        exp_t       e;
        if (nbits == 16 && frame[15]) begin
            addr = int'(frame[14:8]);
            data = frame[7:0];
            if (addr <= 4 && model[addr] != data) begin
                model[addr] = data;
                e.regs = model_vec();
                e.due  = due;
                sb.push_back(e);
            end
        end
    endtask

    task automatic send_frame(input logic [31:0] frame, input int nbits, input int gap);
        wait_clk(1);
        ncs = 1'b0;
        wait_clk(4);
        for (int i = nbits - 1; i >= 0; i--) begin
            copi = frame[i];
            wait_clk(4);
            sclk = 1'b1;
            wait_clk(4);
            sclk = 1'b0;
        end
        wait_clk(4);
        ncs = 1'b1;
        model_frame(frame, nbits, cyc + 5);
        wait_clk(gap);
    endtask

    // Monitor: every register change must match the next scoreboard entry,
    // both in value and in the clock edge it appeared on.
    logic [39:0] prev;
    always @(negedge clk) begin
        logic [39:0] cur;
        exp_t        e;
        cur = {r4, r3, r2, r1, r0};
        if (!rst_n) begin
            prev = cur;
        end else if (cur !== prev) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL spurious_update: got %0h expected %0h (cycle %0d)", cur, prev, cyc);
            end else begin
                e = sb.pop_front();
                check("reg_vector", cur, e.regs);
                check("commit_edge", 64'(cyc), 64'(e.due));
            end
            prev = cur;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] base;
        logic [31:0] frame;
        int          nbits;
        int          pick;

        for (int i = 0; i < 5; i++) model[i] = 8'h00;

        wait_clk(3);
        check_all("reset");
        rst_n = 1'b1;
        wait_clk(3);

        // Single write, exact latency checked by the monitor.
        send_frame(32'h80F0, 16, 6);
        check("t1_out_lo", r0, 8'hF0);
        check("t1_out_hi", r1, 8'h00);
        check("t1_pwm_lo", r2, 8'h00);
        check("t1_pwm_hi", r3, 8'h00);
        check("t1_duty",   r4, 8'h00);

        // Back-to-back at the minimum nCS-high gap.
        send_frame(32'h8480, 16, 4);
        send_frame(32'h8201, 16, 6);
        check("t2_duty",   r4, 8'h80);
        check("t2_pwm_lo", r2, 8'h01);

        // Read frame and out-of-range address are ignored.
        send_frame(32'h0055, 16, 4);
        send_frame(32'h85AA, 16, 6);
        check_all("t3");

        // Short and long frames are ignored; a good one afterwards lands.
        send_frame(32'h813, 12, 6);
        send_frame({14'h0, 16'h813C, 2'b10}, 18, 6);
        check_all("t4_bad");
        send_frame(32'h813C, 16, 6);
        check("t4_out_hi", r1, 8'h3C);

        // Reset in the middle of a frame.
        wait_clk(1);
        ncs = 1'b0;
        wait_clk(4);
        for (int i = 7; i >= 0; i--) begin
            copi = base_bit(8'h83, i);
            wait_clk(4);
            sclk = 1'b1;
            wait_clk(4);
            sclk = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) model[i] = 8'h00;
        check_all("t5_reset");
        ncs  = 1'b1;
        sclk = 1'b0;
        wait_clk(3);
        rst_n = 1'b1;
        wait_clk(6);
        send_frame(32'h83FF, 16, 6);
        check("t5_pwm_hi", r3, 8'hFF);

        // SCLK activity with nCS high must do nothing.
        for (int i = 0; i < 24; i++) begin
            copi = 1'($urandom_range(0, 1));
            sclk = ~sclk;
            wait_clk(3);
        end
        sclk = 1'b0;
        wait_clk(8);
        check_all("t6");

        // Randomized frames: mostly valid writes, some reads, bad addresses and bad lengths.
        for (int n = 0; n < 40; n++) begin
            base[15]   = ($urandom_range(0, 3) != 0);
            base[14:8] = 7'($urandom_range(0, 7));
            base[7:0]  = 8'($urandom);
            pick       = $urandom_range(0, 9);
            if (pick == 0) begin
                nbits = 12;
                frame = {20'h0, base[15:4]};
            end else if (pick == 1) begin
                nbits = 18;
                frame = {14'h0, base, 2'($urandom_range(0, 3))};
            end else begin
                nbits = 16;
                frame = {16'h0, base};
            end
            send_frame(frame, nbits, $urandom_range(4, 8));
        end

        for (int i = 0; i < 100 && sb.size() != 0; i++) wait_clk(1);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        check_all("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    function automatic logic base_bit(input logic [7:0] v, input int i);
        return v[i];
    endfunction

endmodule
